axi_rd_sched: RTL and testbench
===============================

AXI_RD_SCHED -- requirements
Module: axi_rd_sched

Interface
REQ-001 Parameter HRES, default 640, pixels per line.
REQ-002 Parameter VRES, default 480, lines per frame.
REQ-003 Parameter BPP, default 2, bytes per pixel in external memory.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  single-cycle pulse that begins a frame fetch.
REQ-008 frame_base  in  32  frame byte base address, sampled on accepted start.
REQ-009 ready_to_rd  in  1  pixel converter can accept a burst.
REQ-010 mst_length  in  12  requested burst size in pixels.
REQ-011 cmd_req  out  1  read command valid to AXI master.
REQ-012 cmd_addr  out  32  byte address of the command.
REQ-013 cmd_len  out  12  command length in bytes (pixels*BPP).
REQ-014 cmd_ack  in  1  AXI master accepted the command.
REQ-015 rd_valid  in  1  one pixel beat delivered to the converter.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 frame_done  out  1  one-cycle pulse after the last beat of a frame.
REQ-018 err  out  1  sticky beat-protocol error flag.

Function
REQ-019 FSM states: IDLE, ARM, REQ, DATA, NEXT.
REQ-020 IDLE: start=1 loads addr<=frame_base, remaining<=HRES*VRES (24-bit), clears err, goes to ARM next cycle; start outside IDLE ignored.
REQ-021 ARM: ready_to_rd=1 and mst_length!=0 latches burst_px = min(mst_length, remaining), goes to REQ; mst_length=0 holds ARM.
REQ-022 REQ: cmd_req=1, cmd_addr=addr, cmd_len=burst_px*BPP, all registered and stable until cmd_ack; cmd_ack=1 goes to DATA, cmd_req low from next cycle.
REQ-023 DATA: beat counter (12-bit) increments per rd_valid; the beat making count==burst_px goes to NEXT.
REQ-024 NEXT (one cycle): addr<=addr+burst_px*BPP, remaining<=remaining-burst_px; remaining-burst_px==0 pulses frame_done with the transition to IDLE, else to ARM.
REQ-025 Last burst of a frame truncates to remaining pixels (e.g. remaining 100, mst_length 128 -> cmd_len 200).
REQ-026 Address arithmetic is 32-bit modulo 2^32; wrap is not an error.
REQ-027 rd_valid in IDLE, ARM or REQ sets err; beats are not counted there.
REQ-028 cmd_ack outside REQ is ignored.
REQ-029 Command issue latency: ARM with ready_to_rd=1 -> cmd_req high on the second rising edge.
REQ-030 Consecutive bursts: last beat -> next cmd_req no earlier than 3 cycles (NEXT, ARM, REQ).
REQ-031 cmd_ack and rd_valid in the same REQ cycle: transition to DATA, beat flagged err, not counted.

Reset
REQ-032 rst=1 forces IDLE regardless of state, including mid-burst; in-flight beats are abandoned.
REQ-033 Reset values: cmd_req=0, cmd_addr=0, cmd_len=0, busy=0, frame_done=0, err=0, all counters 0.
REQ-034 The first cycle after rst deasserts is IDLE; start on that cycle is accepted.

Verification
REQ-035 start, frame_base=0x1000_0000, mst_length=128, ready_to_rd=1, ack and beats immediate -> 2400 commands, addr step 256, last cmd_addr 0x1009_5F00, single frame_done.
REQ-036 HRES=10, VRES=10, mst_length=32 -> cmd_len 64,64,64,8; frame_done after the 100th beat.
REQ-037 ready_to_rd low for 50 cycles in ARM -> cmd_req stays 0, busy=1; cmd_req rises 2 cycles after ready_to_rd rises.
REQ-038 cmd_ack withheld 20 cycles -> cmd_req, cmd_addr, cmd_len constant throughout; drop 1 cycle after ack.
REQ-039 rd_valid pulse while IDLE -> err=1 and remains 1 until the next accepted start.
REQ-040 rst asserted mid-DATA at beat 60 of 128 -> next cycle cmd_req=0, busy=0; new start restarts from frame_base with the full frame count.

Source files
------------

// File: rtl/axi_rd_sched.sv
// axi_rd_sched: splits a video frame into pixel bursts and issues one AXI
// read command per burst, then counts the returned beats before moving on.
// Address and remaining-pixel bookkeeping advance once per completed burst.
module axi_rd_sched #(
    parameter int HRES = 640,
    parameter int VRES = 480,
    parameter int BPP  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] frame_base,
    input  logic        ready_to_rd,
    input  logic [11:0] mst_length,
    output logic        cmd_req,
    output logic [31:0] cmd_addr,
    output logic [11:0] cmd_len,
    input  logic        cmd_ack,
    input  logic        rd_valid,
    output logic        busy,
    output logic        frame_done,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_REQ  = 3'd2,
        ST_DATA = 3'd3,
        ST_NEXT = 3'd4
    } state_t;

    localparam logic [23:0] FRAME_PX = 24'(HRES * VRES);
    localparam logic [31:0] BPP_W    = 32'(BPP);

    state_t      state_q;
    logic [31:0] addr_q;
    logic [23:0] remaining_q;
    logic [11:0] burst_px_q;
    logic [11:0] beat_cnt_q;
    logic        cmd_req_q;
    logic [31:0] cmd_addr_q;
    logic [11:0] cmd_len_q;
    logic        busy_q;
    logic        frame_done_q;
    logic        err_q;

    logic [11:0] burst_px_d;
    logic [31:0] burst_bytes_d;
    logic [23:0] remaining_d;
    logic [11:0] beat_cnt_d;
    logic        err_set_d;

    // Burst sizing, byte arithmetic and protocol-error detection.
    always_comb begin
        // The last burst of a frame is clipped to whatever pixels remain.
        if ({12'd0, mst_length} < remaining_q) begin
            burst_px_d = mst_length;
        end else begin
            burst_px_d = remaining_q[11:0];
        end
        burst_bytes_d = {20'd0, burst_px_q} * BPP_W;
        remaining_d   = remaining_q - {12'd0, burst_px_q};
        beat_cnt_d    = beat_cnt_q + 12'd1;
        // Beats before the command is accepted cannot belong to a burst.
        if (rd_valid && ((state_q == ST_IDLE) || (state_q == ST_ARM) ||
                         (state_q == ST_REQ))) begin
            err_set_d = 1'b1;
        end else begin
            err_set_d = 1'b0;
        end
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= 32'd0;
            remaining_q  <= 24'd0;
            burst_px_q   <= 12'd0;
            beat_cnt_q   <= 12'd0;
            cmd_req_q    <= 1'b0;
            cmd_addr_q   <= 32'd0;
            cmd_len_q    <= 12'd0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_q      <= frame_base;
                        remaining_q <= FRAME_PX;
                        err_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (ready_to_rd && (mst_length != 12'd0)) begin
                        burst_px_q <= burst_px_d;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // First REQ cycle registers the command; an ack only
                    // counts once the command is actually on the bus.
                    if (!cmd_req_q) begin
                        cmd_req_q  <= 1'b1;
                        cmd_addr_q <= addr_q;
                        cmd_len_q  <= burst_bytes_d[11:0];
                    end else if (cmd_ack) begin
                        cmd_req_q  <= 1'b0;
                        beat_cnt_q <= 12'd0;
                        state_q    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (rd_valid) begin
                        beat_cnt_q <= beat_cnt_d;
                        if (beat_cnt_d == burst_px_q) begin
                            state_q <= ST_NEXT;
                        end
                    end
                end
                ST_NEXT: begin
                    addr_q      <= addr_q + burst_bytes_d;
                    remaining_q <= remaining_d;
                    if (remaining_d == 24'd0) begin
                        frame_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else begin
                        state_q <= ST_ARM;
                    end
                end
                default: begin
                    cmd_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
            if (err_set_d) begin
                err_q <= 1'b1;
            end
        end
    end

    assign cmd_req    = cmd_req_q;
    assign cmd_addr   = cmd_addr_q;
    assign cmd_len    = cmd_len_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_axi_rd_sched.sv
// Randomized self-checking bench for axi_rd_sched on a 10x10, 2-byte frame.
// A frame-level model (remaining pixels, next address) predicts every command.
module tb_axi_rd_sched;

    localparam int HRES  = 10;
    localparam int VRES  = 10;
    localparam int BPP   = 2;
    localparam int FRAME = HRES * VRES;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] frame_base;
    logic        ready_to_rd;
    logic [11:0] mst_length;
    logic        cmd_req;
    logic [31:0] cmd_addr;
    logic [11:0] cmd_len;
    logic        cmd_ack;
    logic        rd_valid;
    logic        busy;
    logic        frame_done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    axi_rd_sched #(.HRES(HRES), .VRES(VRES), .BPP(BPP)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_base(frame_base),
        .ready_to_rd(ready_to_rd), .mst_length(mst_length),
        .cmd_req(cmd_req), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_ack(cmd_ack), .rd_valid(rd_valid), .busy(busy),
        .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    // Holds reset two cycles; returns at a falling edge with rst just released.
    task automatic do_reset();
        rst = 1'b1; start = 1'b0; ready_to_rd = 1'b0; mst_length = 12'd0;
        cmd_ack = 1'b0; rd_valid = 1'b0; frame_base = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (cmd_req !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_req: got %b want 0", cmd_req); end
        n_cmp++; if (cmd_addr !== 32'd0) begin n_bad++; $display("FAIL rst_cmd_addr: got %h want 0", cmd_addr); end
        n_cmp++; if (cmd_len !== 12'd0) begin n_bad++; $display("FAIL rst_cmd_len: got %h want 0", cmd_len); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
    endtask

    // Runs one full frame from IDLE. Negative wait arguments mean random.
    task automatic run_frame(input logic [31:0] base, input int fixed_mst,
                             input int arm_wait, input int ack_wait, input int gap_max);
        logic [31:0] m_addr;
        logic [31:0] h_addr;
        logic [11:0] h_len;
        int rem, px, mst, w, ncmd;
        m_addr = base;
        rem    = FRAME;
        ncmd   = 0;
        start = 1'b1; frame_base = base;
        @(negedge clk);
        start = 1'b0; frame_base = $urandom;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL start_busy: got %b want 1", busy); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL start_err: got %b want 0", err); end
        while (rem > 0) begin
            w = (arm_wait >= 0) ? arm_wait : $urandom_range(0, 3);
            for (int i = 0; i < w; i++) begin
                ready_to_rd = 1'($urandom_range(0, 1));
                mst_length  = ready_to_rd ? 12'd0 : 12'($urandom_range(1, 4095));
                @(negedge clk);
                n_cmp++; if (cmd_req !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL arm_hold: got req=%b busy=%b want req=0 busy=1", cmd_req, busy); end
            end
            if (fixed_mst > 0) mst = fixed_mst;
            else if ($urandom_range(0, 3) == 0) mst = $urandom_range(50, 300);
            else mst = $urandom_range(1, 40);
            px = (mst < rem) ? mst : rem;
            ready_to_rd = 1'b1; mst_length = 12'(mst);
            @(negedge clk);
            n_cmp++; if (cmd_req !== 1'b0) begin n_bad++; $display("FAIL issue_early: got %b want 0", cmd_req); end
            ready_to_rd = 1'($urandom_range(0, 1)); mst_length = 12'($urandom);
            @(negedge clk);
            ready_to_rd = 1'b0;
            n_cmp++; if (cmd_req !== 1'b1) begin n_bad++; $display("FAIL issue_latency: got %b want 1", cmd_req); end
            n_cmp++; if (cmd_addr !== m_addr) begin n_bad++; $display("FAIL cmd_addr[%0d]: got %h want %h", ncmd, cmd_addr, m_addr); end
            n_cmp++; if (cmd_len !== 12'(px * BPP)) begin n_bad++; $display("FAIL cmd_len[%0d]: got %0d want %0d", ncmd, cmd_len, px * BPP); end
            h_addr = cmd_addr; h_len = cmd_len;
            w = (ack_wait >= 0) ? ack_wait : $urandom_range(0, 4);
            for (int i = 0; i < w; i++) begin
                @(negedge clk);
                n_cmp++; if (cmd_req !== 1'b1 || cmd_addr !== h_addr || cmd_len !== h_len) begin n_bad++; $display("FAIL cmd_stable: got req=%b addr=%h len=%h want 1 %h %h", cmd_req, cmd_addr, cmd_len, h_addr, h_len); end
            end
            cmd_ack = 1'b1;
            @(negedge clk);
            cmd_ack = 1'b0;
            n_cmp++; if (cmd_req !== 1'b0) begin n_bad++; $display("FAIL ack_drop: got %b want 0", cmd_req); end
            for (int b = 0; b < px; b++) begin
                w = $urandom_range(0, gap_max);
                for (int g = 0; g < w; g++) begin
                    cmd_ack = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                rd_valid = 1'b1;
                @(negedge clk);
                rd_valid = 1'b0;
            end
            cmd_ack = 1'b0;
            n_cmp++; if (busy !== 1'b1 || frame_done !== 1'b0 || cmd_req !== 1'b0) begin n_bad++; $display("FAIL after_last_beat: got busy=%b fd=%b req=%b want 1 0 0", busy, frame_done, cmd_req); end
            @(negedge clk);
            rem    = rem - px;
            m_addr = m_addr + 32'(px * BPP);
            ncmd++;
            if (rem == 0) begin
                n_cmp++; if (frame_done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL frame_end: got fd=%b busy=%b want 1 0", frame_done, busy); end
            end else begin
                n_cmp++; if (frame_done !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL mid_frame: got fd=%b busy=%b want 0 1", frame_done, busy); end
            end
        end
        @(negedge clk);
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL frame_done_single: got %b want 0", frame_done); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL frame_err: got %b want 0", err); end
    endtask

    task automatic test_fixed_frame();
        run_frame(32'h1000_0000, 32, 0, 0, 0);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 4; f++) run_frame($urandom, 0, -1, -1, 2);
    endtask

    task automatic test_arm_stall();
        run_frame(32'h2000_0040, 0, 50, -1, 1);
    endtask

    task automatic test_ack_hold();
        run_frame(32'h0000_8000, 0, -1, 20, 1);
    endtask

    task automatic test_wrap();
        run_frame(32'hFFFF_FFC0, 0, -1, -1, 1);
    endtask

    task automatic test_err();
        do_reset();
        @(negedge clk);
        rd_valid = 1'b1; cmd_ack = 1'b1;
        @(negedge clk);
        rd_valid = 1'b0; cmd_ack = 1'b0;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_idle_set: got %b want 1", err); end
        n_cmp++; if (cmd_req !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL idle_ack_ignored: got req=%b busy=%b want 0 0", cmd_req, busy); end
        repeat (5) @(negedge clk);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err); end
        start = 1'b1; frame_base = 32'h3000_0000;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear_on_start: got %b want 0", err); end
        rd_valid = 1'b1;
        @(negedge clk);
        rd_valid = 1'b0;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_arm_set: got %b want 1", err); end
        start = 1'b1; frame_base = 32'h4000_0000;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL start_in_arm_ignored: got err=%b want 1", err); end
        do_reset();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_after_rst: got %b want 0", err); end
    endtask

    task automatic test_ack_beat_same();
        logic [31:0] base;
        logic        seen;
        base = 32'h5000_0100;
        start = 1'b1; frame_base = base;
        @(negedge clk);
        start = 1'b0; ready_to_rd = 1'b1; mst_length = 12'd4;
        @(negedge clk);
        ready_to_rd = 1'b0;
        @(negedge clk);
        n_cmp++; if (cmd_req !== 1'b1 || cmd_len !== 12'd8) begin n_bad++; $display("FAIL ab_issue: got req=%b len=%0d want 1 8", cmd_req, cmd_len); end
        cmd_ack = 1'b1; rd_valid = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0; rd_valid = 1'b0;
        n_cmp++; if (err !== 1'b1 || cmd_req !== 1'b0) begin n_bad++; $display("FAIL ab_err: got err=%b req=%b want 1 0", err, cmd_req); end
        for (int b = 0; b < 3; b++) begin
            rd_valid = 1'b1;
            @(negedge clk);
            rd_valid = 1'b0;
        end
        ready_to_rd = 1'b1; mst_length = 12'd4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (cmd_req !== 1'b0) begin n_bad++; $display("FAIL ab_beat_uncounted: got req=%b want 0", cmd_req); end
        end
        rd_valid = 1'b1;
        @(negedge clk);
        rd_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            seen = cmd_req;
        end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL ab_next_cmd_timeout: got %b want 1", seen); end
        n_cmp++; if (cmd_addr !== base + 32'd8) begin n_bad++; $display("FAIL ab_next_addr: got %h want %h", cmd_addr, base + 32'd8); end
        ready_to_rd = 1'b0;
        do_reset();
    endtask

    task automatic test_rst_mid();
        start = 1'b1; frame_base = 32'h6000_0000;
        @(negedge clk);
        start = 1'b0; ready_to_rd = 1'b1; mst_length = 12'd80;
        @(negedge clk);
        ready_to_rd = 1'b0;
        @(negedge clk);
        n_cmp++; if (cmd_req !== 1'b1 || cmd_len !== 12'd160) begin n_bad++; $display("FAIL rm_issue: got req=%b len=%0d want 1 160", cmd_req, cmd_len); end
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        rd_valid = 1'b1;
        repeat (60) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rd_valid = 1'b0;
        n_cmp++; if (cmd_req !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rm_outputs: got req=%b busy=%b want 0 0", cmd_req, busy); end
        n_cmp++; if (cmd_addr !== 32'd0 || err !== 1'b0) begin n_bad++; $display("FAIL rm_clear: got addr=%h err=%b want 0 0", cmd_addr, err); end
        rst = 1'b0;
        run_frame(32'h7000_0200, 0, -1, -1, 1);
    endtask

    initial begin
        test_reset();
        test_fixed_frame();
        test_random_frames();
        test_arm_stall();
        test_ack_hold();
        test_wrap();
        test_err();
        test_ack_beat_same();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
